// File: rtl/river_pkg.sv
// Shared RiVer pipeline types: access sizes, MEM->WBK entry layout, MEM FSM states,
// plus the lane helpers used by the memory stage.
package river_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  dest;
        logic        wb;
        logic [31:0] pc;
        logic [31:0] csr_rdata;
        logic        csr_we;
        logic        mult;
    } mem2wbk_entry_t;

    // Code 11 has no access size of its own and behaves as a word access.
    function automatic mem_size_t decode_size(logic [1:0] code);
        mem_size_t size;
        case (code)
            2'b00:   size = BYTE;
            2'b01:   size = HALF;
            default: size = WORD;
        endcase
        return size;
    endfunction

    function automatic logic [3:0] byte_sel(mem_size_t size, logic [1:0] off);
        logic [3:0] sel;
        case (size)
            BYTE:    sel = 4'b0001 << off;
            HALF:    sel = 4'b0011 << off;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_data(mem_size_t size, logic [31:0] d);
        logic [31:0] lanes;
        case (size)
            BYTE:    lanes = {4{d[7:0]}};
            HALF:    lanes = {2{d[15:0]}};
            default: lanes = d;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_align(logic [31:0] word, logic [1:0] off,
                                               mem_size_t size, logic sign);
        logic [31:0] sh;
        logic [31:0] val;
        sh = word >> {off, 3'b000};
        case (size)
            BYTE:    val = {{24{sign & sh[7]}}, sh[7:0]};
            HALF:    val = {{16{sign & sh[15]}}, sh[15:0]};
            default: val = sh;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/mem2wbk_fifo.sv
// Two-entry MEM->WBK FIFO. Push is dropped when full, pop is dropped when empty;
// a simultaneous push and pop at count 1 leaves the new entry at the head.
module mem2wbk_fifo
    import river_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  mem2wbk_entry_t push_data,
    input  logic           pop,
    output mem2wbk_entry_t head,
    output logic           full,
    output logic           empty
);

    mem2wbk_entry_t entries_q [FIFO_DEPTH];
    logic           wr_ptr_q;
    logic           rd_ptr_q;
    logic [1:0]     count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == 2'(FIFO_DEPTH));
    assign empty   = (count_q == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entries_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                entries_q[wr_ptr_q] <= push_data;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// RiVer memory stage: issues load/store requests to the data cache, waits out misses,
// aligns/extends load data and queues one result per instruction for writeback.
module mem_stage
    import river_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] EXE_RES_RE,
    input  logic [31:0] MEM_DATA_RE,
    input  logic [5:0]  EXE_DEST_RE,
    input  logic        WB_RE,
    input  logic [31:0] PC_EXE2MEM_RE,
    input  logic        MEM_LOAD_RE,
    input  logic        MEM_STORE_RE,
    input  logic [1:0]  MEM_SIZE_RE,
    input  logic        MEM_SIGN_EXTEND_RE,
    input  logic        CSR_WENABLE_RE,
    input  logic [31:0] CSR_RDATA_RE,
    input  logic        MULT_INST_RE,
    input  logic        EXE2MEM_EMPTY_SE,
    output logic        EXE2MEM_POP_SM,
    output logic [31:0] MCACHE_ADR_SM,
    output logic [31:0] MCACHE_DATA_SM,
    output logic        MCACHE_ADR_VALID_SM,
    output logic        MCACHE_WE_SM,
    output logic [3:0]  MCACHE_BYT_SEL_SM,
    input  logic [31:0] MCACHE_RESULT_SM,
    input  logic        MCACHE_STALL_SM,
    output logic        MISALIGN_SM,
    output logic [31:0] MEM_RES_RM,
    output logic [5:0]  MEM_DEST_RM,
    output logic        WB_RM,
    output logic [31:0] PC_MEM2WBK_RM,
    output logic [31:0] CSR_RDATA_RM,
    output logic        CSR_WENABLE_RM,
    output logic        MULT_INST_RM,
    output logic        MEM2WBK_EMPTY_SM,
    input  logic        MEM2WBK_POP_SW
);

    mem_state_t     state_q, state_d;
    mem2wbk_entry_t head_entry, push_data, fifo_head;
    mem_size_t      size_eff;
    logic [1:0]     off;
    logic           is_mem, misaligned, can_go, full, push, pop, latch_en;

    // Request captured on a miss; the upstream head is not trusted after that.
    logic [31:0]    lat_adr_q, lat_data_q;
    logic [3:0]     lat_sel_q;
    logic           lat_we_q, lat_sign_q;
    logic [1:0]     lat_off_q;
    mem_size_t      lat_size_q;
    mem2wbk_entry_t lat_entry_q;

    assign size_eff   = decode_size(MEM_SIZE_RE);
    assign off        = EXE_RES_RE[1:0];
    assign is_mem     = MEM_LOAD_RE | MEM_STORE_RE;
    assign misaligned = is_mem && ((size_eff == HALF && off[0]) ||
                                   (size_eff == WORD && off != 2'b00));
    // Reset also gates the issue path so nothing leaks out while it is held.
    assign can_go     = !reset && !EXE2MEM_EMPTY_SE && !full;

    assign head_entry = '{res: EXE_RES_RE, dest: EXE_DEST_RE, wb: WB_RE, pc: PC_EXE2MEM_RE,
                          csr_rdata: CSR_RDATA_RE, csr_we: CSR_WENABLE_RE, mult: MULT_INST_RE};

    always_comb begin
        state_d             = state_q;
        pop                 = 1'b0;
        push                = 1'b0;
        latch_en            = 1'b0;
        push_data           = head_entry;
        MISALIGN_SM         = 1'b0;
        MCACHE_ADR_VALID_SM = 1'b0;
        MCACHE_ADR_SM       = '0;
        MCACHE_DATA_SM      = '0;
        MCACHE_WE_SM        = 1'b0;
        MCACHE_BYT_SEL_SM   = '0;
        unique case (state_q)
            RUN: begin
                if (can_go) begin
                    if (!is_mem) begin
                        pop  = 1'b1;
                        push = 1'b1;
                    end else if (misaligned) begin
                        MISALIGN_SM  = 1'b1;
                        pop          = 1'b1;
                        push         = 1'b1;
                        push_data.wb = 1'b0;
                    end else begin
                        MCACHE_ADR_VALID_SM = 1'b1;
                        MCACHE_ADR_SM       = {EXE_RES_RE[31:2], 2'b00};
                        MCACHE_DATA_SM      = store_data(size_eff, MEM_DATA_RE);
                        MCACHE_WE_SM        = MEM_STORE_RE;
                        MCACHE_BYT_SEL_SM   = byte_sel(size_eff, off);
                        if (!MCACHE_STALL_SM) begin
                            pop           = 1'b1;
                            push          = 1'b1;
                            push_data.res = MEM_STORE_RE ? 32'd0 :
                                load_align(MCACHE_RESULT_SM, off, size_eff, MEM_SIGN_EXTEND_RE);
                        end else begin
                            latch_en = 1'b1;
                            state_d  = MISS_WAIT;
                        end
                    end
                end
            end
            MISS_WAIT: begin
                MCACHE_ADR_VALID_SM = 1'b1;
                MCACHE_ADR_SM       = lat_adr_q;
                MCACHE_DATA_SM      = lat_data_q;
                MCACHE_WE_SM        = lat_we_q;
                MCACHE_BYT_SEL_SM   = lat_sel_q;
                if (!MCACHE_STALL_SM) begin
                    pop           = 1'b1;
                    push          = 1'b1;
                    push_data     = lat_entry_q;
                    push_data.res = lat_we_q ? lat_entry_q.res :
                        load_align(MCACHE_RESULT_SM, lat_off_q, lat_size_q, lat_sign_q);
                    state_d       = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            lat_adr_q   <= '0;
            lat_data_q  <= '0;
            lat_sel_q   <= '0;
            lat_we_q    <= 1'b0;
            lat_sign_q  <= 1'b0;
            lat_off_q   <= '0;
            lat_size_q  <= BYTE;
            lat_entry_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                lat_adr_q   <= MCACHE_ADR_SM;
                lat_data_q  <= MCACHE_DATA_SM;
                lat_sel_q   <= MCACHE_BYT_SEL_SM;
                lat_we_q    <= MCACHE_WE_SM;
                lat_sign_q  <= MEM_SIGN_EXTEND_RE;
                lat_off_q   <= off;
                lat_size_q  <= size_eff;
                // res is zero so a completed store pushes 0 straight from the latch.
                lat_entry_q <= '{res: '0, dest: EXE_DEST_RE, wb: WB_RE, pc: PC_EXE2MEM_RE,
                                 csr_rdata: CSR_RDATA_RE, csr_we: CSR_WENABLE_RE,
                                 mult: MULT_INST_RE};
            end
        end
    end

    assign EXE2MEM_POP_SM = pop;

    mem2wbk_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (MEM2WBK_POP_SW),
        .head      (fifo_head),
        .full      (full),
        .empty     (MEM2WBK_EMPTY_SM)
    );

    assign MEM_RES_RM     = fifo_head.res;
    assign MEM_DEST_RM    = fifo_head.dest;
    assign WB_RM          = fifo_head.wb;
    assign PC_MEM2WBK_RM  = fifo_head.pc;
    assign CSR_RDATA_RM   = fifo_head.csr_rdata;
    assign CSR_WENABLE_RM = fifo_head.csr_we;
    assign MULT_INST_RM   = fifo_head.mult;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: byte-addressed reference memory model,
// a cache model fed by the DUT's own requests, and a separate writeback-side monitor.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] EXE_RES_RE, MEM_DATA_RE, PC_EXE2MEM_RE, CSR_RDATA_RE;
    logic [5:0]  EXE_DEST_RE;
    logic        WB_RE, MEM_LOAD_RE, MEM_STORE_RE, MEM_SIGN_EXTEND_RE;
    logic [1:0]  MEM_SIZE_RE;
    logic        CSR_WENABLE_RE, MULT_INST_RE, EXE2MEM_EMPTY_SE, EXE2MEM_POP_SM;
    logic [31:0] MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_RESULT_SM;
    logic        MCACHE_ADR_VALID_SM, MCACHE_WE_SM, MCACHE_STALL_SM, MISALIGN_SM;
    logic [3:0]  MCACHE_BYT_SEL_SM;
    logic [31:0] MEM_RES_RM, PC_MEM2WBK_RM, CSR_RDATA_RM;
    logic [5:0]  MEM_DEST_RM;
    logic        WB_RM, CSR_WENABLE_RM, MULT_INST_RM, MEM2WBK_EMPTY_SM, MEM2WBK_POP_SW;

    typedef struct {
        bit          ld, st, sx, wb, csr_we, mult;
        logic [1:0]  size;
        logic [31:0] res, data, pc, csr_rd;
        logic [5:0]  dest;
    } instr_t;

    typedef struct {
        logic [31:0] res, pc, csr_rd;
        logic [5:0]  dest;
        logic        wb, csr_we, mult;
    } exp_t;

    instr_t      up_q [$];
    exp_t        exp_q [$];
    logic [7:0]  ref_mem [64];
    logic [31:0] cache [16];
    bit          popped;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    assign MCACHE_RESULT_SM = cache[MCACHE_ADR_SM[5:2]];

    mem_stage #(.FIFO_DEPTH(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .EXE_RES_RE          (EXE_RES_RE),
        .MEM_DATA_RE         (MEM_DATA_RE),
        .EXE_DEST_RE         (EXE_DEST_RE),
        .WB_RE               (WB_RE),
        .PC_EXE2MEM_RE       (PC_EXE2MEM_RE),
        .MEM_LOAD_RE         (MEM_LOAD_RE),
        .MEM_STORE_RE        (MEM_STORE_RE),
        .MEM_SIZE_RE         (MEM_SIZE_RE),
        .MEM_SIGN_EXTEND_RE  (MEM_SIGN_EXTEND_RE),
        .CSR_WENABLE_RE      (CSR_WENABLE_RE),
        .CSR_RDATA_RE        (CSR_RDATA_RE),
        .MULT_INST_RE        (MULT_INST_RE),
        .EXE2MEM_EMPTY_SE    (EXE2MEM_EMPTY_SE),
        .EXE2MEM_POP_SM      (EXE2MEM_POP_SM),
        .MCACHE_ADR_SM       (MCACHE_ADR_SM),
        .MCACHE_DATA_SM      (MCACHE_DATA_SM),
        .MCACHE_ADR_VALID_SM (MCACHE_ADR_VALID_SM),
        .MCACHE_WE_SM        (MCACHE_WE_SM),
        .MCACHE_BYT_SEL_SM   (MCACHE_BYT_SEL_SM),
        .MCACHE_RESULT_SM    (MCACHE_RESULT_SM),
        .MCACHE_STALL_SM     (MCACHE_STALL_SM),
        .MISALIGN_SM         (MISALIGN_SM),
        .MEM_RES_RM          (MEM_RES_RM),
        .MEM_DEST_RM         (MEM_DEST_RM),
        .WB_RM               (WB_RM),
        .PC_MEM2WBK_RM       (PC_MEM2WBK_RM),
        .CSR_RDATA_RM        (CSR_RDATA_RM),
        .CSR_WENABLE_RM      (CSR_WENABLE_RM),
        .MULT_INST_RM        (MULT_INST_RM),
        .MEM2WBK_EMPTY_SM    (MEM2WBK_EMPTY_SM),
        .MEM2WBK_POP_SW      (MEM2WBK_POP_SW)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int unsigned width_of(logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misal_of(instr_t i);
        return (i.ld || i.st) && ((i.res % width_of(i.size)) != 0);
    endfunction

    function automatic instr_t mk(bit ld, bit st, logic [1:0] size, bit sx, logic [31:0] res,
                                  logic [31:0] data, logic [5:0] dest, bit wb);
        instr_t i;
        i.ld = ld; i.st = st; i.size = size; i.sx = sx; i.res = res; i.data = data;
        i.dest = dest; i.wb = wb; i.pc = $urandom(); i.csr_rd = $urandom();
        i.csr_we = 1'($urandom() % 2); i.mult = 1'($urandom() % 2);
        return i;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        cache[a[5:2]] = v;
        for (int k = 0; k < 4; k++) ref_mem[{a[5:2], 2'b00} + k] = 8'(v >> (8 * k));
    endtask

    // Reference model: little-endian byte memory, results computed per instruction in order.
    task automatic issue(input instr_t i);
        exp_t        e;
        int unsigned n, base;
        logic [31:0] v;
        n = width_of(i.size);
        base = i.res[5:0];
        e = '{res: i.res, pc: i.pc, csr_rd: i.csr_rd, dest: i.dest, wb: i.wb,
              csr_we: i.csr_we, mult: i.mult};
        if (misal_of(i)) begin
            e.wb = 1'b0;
        end else if (i.st) begin
            e.res = 32'd0;
            for (int k = 0; k < n; k++) ref_mem[base + k] = 8'(i.data >> (8 * k));
        end else if (i.ld) begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
            if (i.sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.res = v;
        end
        up_q.push_back(i);
        exp_q.push_back(e);
    endtask

    task automatic drive_head();
        instr_t h;
        if (up_q.size() > 0) begin
            h = up_q[0];
            EXE_RES_RE = h.res; MEM_DATA_RE = h.data; EXE_DEST_RE = h.dest; WB_RE = h.wb;
            PC_EXE2MEM_RE = h.pc; MEM_LOAD_RE = h.ld; MEM_STORE_RE = h.st;
            MEM_SIZE_RE = h.size; MEM_SIGN_EXTEND_RE = h.sx; CSR_WENABLE_RE = h.csr_we;
            CSR_RDATA_RE = h.csr_rd; MULT_INST_RE = h.mult; EXE2MEM_EMPTY_SE = 1'b0;
        end else begin
            EXE2MEM_EMPTY_SE = 1'b1; MEM_LOAD_RE = 1'b0; MEM_STORE_RE = 1'b0;
        end
    endtask

    // Checks the upstream/cache side of the current cycle and performs the cache write.
    task automatic observe();
        instr_t      h;
        bit          have;
        int unsigned n, off;
        logic [31:0] ed;
        logic [3:0]  es;
        have = up_q.size() > 0;
        if (have) h = up_q[0];
        chk("misalign_pulse", 32'(MISALIGN_SM),
            32'(have && EXE2MEM_POP_SM && misal_of(h)));
        if (MCACHE_ADR_VALID_SM) begin
            if (!have) begin
                chk("req_no_head", 32'(MCACHE_ADR_VALID_SM), 32'd0);
            end else begin
                n = width_of(h.size);
                off = h.res[1:0];
                es = '0;
                for (int k = 0; k < n; k++) es[off + k] = 1'b1;
                for (int l = 0; l < 4; l++) ed[8 * l +: 8] = 8'(h.data >> (8 * (l % n)));
                chk("req_for_aligned_mem", 32'((h.ld || h.st) && !misal_of(h)), 32'd1);
                chk("req_adr", MCACHE_ADR_SM, h.res & ~32'd3);
                chk("req_we", 32'(MCACHE_WE_SM), 32'(h.st));
                chk("req_sel", 32'(MCACHE_BYT_SEL_SM), 32'(es));
                if (h.st) chk("req_data", MCACHE_DATA_SM, ed);
                if (!MCACHE_STALL_SM && MCACHE_WE_SM) begin
                    for (int l = 0; l < 4; l++) begin
                        if (MCACHE_BYT_SEL_SM[l])
                            cache[MCACHE_ADR_SM[5:2]][8 * l +: 8] = MCACHE_DATA_SM[8 * l +: 8];
                    end
                end
            end
        end
        if (EXE2MEM_POP_SM && !have) chk("pop_no_head", 32'(EXE2MEM_POP_SM), 32'd0);
        popped = EXE2MEM_POP_SM && have;
    endtask

    task automatic step(input bit stall, input bit wpop);
        @(negedge clk);
        if (popped) up_q.delete(0);
        popped = 1'b0;
        drive_head();
        MCACHE_STALL_SM = stall;
        MEM2WBK_POP_SW = wpop;
        #1;
        observe();
    endtask

    // Writeback-side monitor: compares the FIFO head whenever it is consumed.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && MEM2WBK_POP_SW && !MEM2WBK_EMPTY_SM) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(MEM2WBK_EMPTY_SM), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wbk_res", MEM_RES_RM, e.res);
                chk("wbk_dest", 32'(MEM_DEST_RM), 32'(e.dest));
                chk("wbk_pc", PC_MEM2WBK_RM, e.pc);
                chk("wbk_csr_rdata", CSR_RDATA_RM, e.csr_rd);
                chk("wbk_flags", 32'({WB_RM, CSR_WENABLE_RM, MULT_INST_RM}),
                    32'({e.wb, e.csr_we, e.mult}));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MCACHE_STALL_SM = 1'b0; MEM2WBK_POP_SW = 1'b0; popped = 1'b0;
        EXE_RES_RE = '0; MEM_DATA_RE = '0; EXE_DEST_RE = '0; WB_RE = 1'b0;
        PC_EXE2MEM_RE = '0; MEM_SIZE_RE = '0; MEM_SIGN_EXTEND_RE = 1'b0;
        CSR_WENABLE_RE = 1'b0; CSR_RDATA_RE = '0; MULT_INST_RE = 1'b0;
        drive_head();
        for (int w = 0; w < 16; w++) set_word(32'(w * 4), $urandom());
        repeat (2) @(negedge clk);
        #1;
        chk("rst_empty", 32'(MEM2WBK_EMPTY_SM), 32'd1);
        chk("rst_pop", 32'(EXE2MEM_POP_SM), 32'd0);
        chk("rst_valid", 32'(MCACHE_ADR_VALID_SM), 32'd0);
        chk("rst_res", MEM_RES_RM, 32'd0);
        chk("rst_pc", PC_MEM2WBK_RM, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Non-memory op
        issue(mk(0, 0, 2'd0, 0, 32'h1234, 32'd0, 6'd5, 1));
        step(0, 1);
        step(0, 1);
        chk("alu_empty", 32'(MEM2WBK_EMPTY_SM), 32'd0);
        chk("alu_res", MEM_RES_RM, 32'h1234);
        chk("alu_dest", 32'(MEM_DEST_RM), 32'd5);

        // Signed and unsigned byte loads
        set_word(32'h1000, 32'h80FF_0000);
        issue(mk(1, 0, 2'd0, 1, 32'h1003, 32'd0, 6'd7, 1));
        step(0, 0);
        step(0, 1);
        chk("lb_res", MEM_RES_RM, 32'hFFFF_FF80);
        issue(mk(1, 0, 2'd0, 0, 32'h1003, 32'd0, 6'd7, 1));
        step(0, 0);
        step(0, 1);
        chk("lbu_res", MEM_RES_RM, 32'h0000_0080);

        // Halfword store
        issue(mk(0, 1, 2'd1, 0, 32'h2002, 32'h0000_ABCD, 6'd0, 0));
        step(0, 0);
        chk("sh_sel", 32'(MCACHE_BYT_SEL_SM), 32'hC);
        chk("sh_data", MCACHE_DATA_SM, 32'hABCD_ABCD);
        chk("sh_we", 32'(MCACHE_WE_SM), 32'd1);
        step(0, 1);
        chk("sh_res", MEM_RES_RM, 32'd0);

        // Cache miss with three stall cycles
        set_word(32'h1008, 32'hCAFE_F00D);
        issue(mk(1, 0, 2'd2, 0, 32'h1008, 32'd0, 6'd9, 1));
        repeat (3) begin
            step(1, 1);
            chk("miss_valid", 32'(MCACHE_ADR_VALID_SM), 32'd1);
            chk("miss_adr", MCACHE_ADR_SM, 32'h1008);
            chk("miss_no_pop", 32'(EXE2MEM_POP_SM), 32'd0);
        end
        step(0, 1);
        chk("miss_done_pop", 32'(EXE2MEM_POP_SM), 32'd1);
        step(0, 1);
        chk("miss_visible", 32'(MEM2WBK_EMPTY_SM), 32'd0);
        chk("miss_res", MEM_RES_RM, 32'hCAFE_F00D);

        // FIFO full back-pressure
        for (int k = 0; k < 3; k++) issue(mk(0, 0, 2'd0, 0, $urandom(), 32'd0, 6'(k + 1), 1));
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("full_no_pop", 32'(EXE2MEM_POP_SM), 32'd0);
        step(0, 1);
        chk("full_no_pop_on_drain", 32'(EXE2MEM_POP_SM), 32'd0);
        step(0, 0);
        chk("full_resume_pop", 32'(EXE2MEM_POP_SM), 32'd1);
        repeat (3) step(0, 1);

        // Misaligned word load
        issue(mk(1, 0, 2'd2, 0, 32'h3001, 32'd0, 6'd3, 1));
        step(0, 1);
        chk("mis_pulse", 32'(MISALIGN_SM), 32'd1);
        chk("mis_no_valid", 32'(MCACHE_ADR_VALID_SM), 32'd0);
        chk("mis_pop", 32'(EXE2MEM_POP_SM), 32'd1);
        step(0, 1);
        chk("mis_pulse_end", 32'(MISALIGN_SM), 32'd0);
        chk("mis_wb", 32'(WB_RM), 32'd0);
        chk("mis_res", MEM_RES_RM, 32'h3001);
        step(0, 1);

        // Reset during MISS_WAIT
        issue(mk(0, 0, 2'd0, 0, 32'h55, 32'd0, 6'd1, 1));
        issue(mk(1, 0, 2'd2, 0, 32'h1004, 32'd0, 6'd2, 1));
        step(0, 0);
        step(1, 0);
        step(1, 0);
        chk("rstw_valid_before", 32'(MCACHE_ADR_VALID_SM), 32'd1);
        chk("rstw_nonempty", 32'(MEM2WBK_EMPTY_SM), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rstw_valid_drop", 32'(MCACHE_ADR_VALID_SM), 32'd0);
        chk("rstw_empty", 32'(MEM2WBK_EMPTY_SM), 32'd1);
        chk("rstw_res", MEM_RES_RM, 32'd0);
        up_q.delete();
        exp_q.delete();
        popped = 1'b0;
        drive_head();
        MCACHE_STALL_SM = 1'b0;
        @(negedge clk) reset = 1'b0;

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            if (up_q.size() < 3 && ($urandom() % 4) != 0) begin
                int unsigned kind;
                logic [31:0] a;
                kind = $urandom_range(0, 3);
                a = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
                issue(mk(kind == 1 || kind == 2, kind == 3, 2'($urandom_range(0, 3)),
                         1'($urandom() % 2), kind == 0 ? $urandom() : a, $urandom(),
                         6'($urandom()), 1'($urandom() % 2)));
            end
            step(($urandom() % 3) == 0, ($urandom() % 4) != 0);
        end

        for (int c = 0; c < 100; c++) begin
            if (up_q.size() == 0 && exp_q.size() == 0 && MEM2WBK_EMPTY_SM) break;
            step(0, 1);
        end
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("drain_upstream", 32'(up_q.size()), 32'd0);
        chk("drain_empty", 32'(MEM2WBK_EMPTY_SM), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RiVer pipeline. It pops instructions from the EXE→MEM FIFO and performs load/store accesses on the data cache with a miss-wait state machine. It aligns and extends load data, then pushes one result entry per instruction into an internal 2-entry MEM→WBK FIFO. The writeback stage drains that FIFO through the `*_RM` / `MEM2WBK_EMPTY_SM` / `MEM2WBK_POP_SW` interface.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: MEM→WBK entries; must be 2, other values unsupported.

Ports:
- `clk`  in  1  clock; everything samples on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `EXE_RES_RE`  in  32  ALU result, or effective address for memory ops.
- `MEM_DATA_RE`  in  32  store data.
- `EXE_DEST_RE`  in  6  destination register.
- `WB_RE`  in  1  writes a register.
- `PC_EXE2MEM_RE`  in  32  instruction PC.
- `MEM_LOAD_RE`, `MEM_STORE_RE`  in  1 each  access type; never both set.
- `MEM_SIZE_RE`  in  2  00 byte, 01 half, 10 word.
- `MEM_SIGN_EXTEND_RE`  in  1  sign-extend loads.
- `CSR_WENABLE_RE`  in  1  CSR instruction flag, passed through.
- `CSR_RDATA_RE`  in  32  CSR read data, passed through.
- `MULT_INST_RE`  in  1  multiply flag, passed through.
- `EXE2MEM_EMPTY_SE`  in  1  upstream FIFO empty.
- `EXE2MEM_POP_SM`  out  1  pop upstream head.
- `MCACHE_ADR_SM`  out  32  word-aligned address.
- `MCACHE_DATA_SM`  out  32  lane-replicated store data.
- `MCACHE_ADR_VALID_SM`  out  1  request valid.
- `MCACHE_WE_SM`  out  1  store.
- `MCACHE_BYT_SEL_SM`  out  4  byte lanes.
- `MCACHE_RESULT_SM`  in  32  read word; valid in the cycle the request completes.
- `MCACHE_STALL_SM`  in  1  request not accepted this cycle.
- `MISALIGN_SM`  out  1  one-cycle pulse on a misaligned access.
- `MEM_RES_RM`, `MEM_DEST_RM`, `WB_RM`, `PC_MEM2WBK_RM`, `CSR_RDATA_RM`, `CSR_WENABLE_RM`, `MULT_INST_RM`  out  32/6/1/32/32/1/1  FIFO head fields.
- `MEM2WBK_EMPTY_SM`  out  1  FIFO empty.
- `MEM2WBK_POP_SW`  in  1  pop head; ignored when empty.

## Operation
- **Reset values.**
  - FSM in RUN; FIFO empty, so `MEM2WBK_EMPTY_SM`=1.
  - All other outputs are 0, including all head fields.
- **`can_go` condition.** `!EXE2MEM_EMPTY_SE && !full`, where `full` is registered.
- **RUN state.**
  - *Non-memory op with `can_go`:* pop upstream and push the entry. `res` = `EXE_RES_RE`.
  - *Memory op with `can_go`:* drive the request combinationally. Address is `{EXE_RES_RE[31:2],2'b00}`, `VALID`=1, `WE`=`MEM_STORE_RE`.
    - If `MCACHE_STALL_SM`=0: the access completes, pop and push in the same cycle.
    - If `MCACHE_STALL_SM`=1: latch the request fields and the head entry, then go to MISS_WAIT. No pop.
- **MISS_WAIT state.**
  - Drive the latched request every cycle.
  - On the first cycle with `STALL`=0: complete the access, pop, push, return to RUN.
  - Head changes while in MISS_WAIT are ignored; the latched copy is authoritative.
- **Byte select.** byte `4'b0001<<a[1:0]`; half `4'b0011<<a[1:0]`; word `4'b1111`.
- **Store data.** byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
- **Load result.** `r = MCACHE_RESULT_SM >> (8*a[1:0])`; truncate to the access size.
  - Sign-extend when `MEM_SIGN_EXTEND_RE`=1, otherwise zero-extend.
  - Stores push `res` = 0 with `WB` as given by upstream.
- **Misaligned access.** Half with `a[0]`=1, or word with `a[1:0]`≠0.
  - No cache request is issued.
  - `MISALIGN_SM` pulses for one cycle.
  - The entry is popped and pushed with `WB`=0 and `res`=`EXE_RES_RE`.
- **FIFO.**
  - Push allowed only when not full.
  - Push and pop in the same cycle with count 1: count stays 1, the new entry becomes head.
  - With count 2: pop only, never push.
  - Pop when empty has no effect.
- **Size code 11.** Treated as word.

## Timing
- Non-memory op, or load hit, popped in cycle N: entry is visible at `*_RM` with `EMPTY`=0 from cycle N+1.
- Miss with k stall cycles: visible at N+1+k.
- `EXE2MEM_POP_SM` and the cache request are combinational on the current state and inputs. At most one pop per cycle.
- Reset asserted mid-MISS_WAIT: request drops immediately (asynchronous), FIFO clears, FSM returns to RUN. The in-flight access is abandoned.
- The WBK side may pop every cycle. Sustained throughput is 1 instruction per cycle while neither `full` nor `STALL` is set.

## Structure
- Shared package `river_pkg`:
  - `mem_size_t` enum (BYTE, HALF, WORD).
  - `mem2wbk_entry_t` packed struct (res, dest, wb, pc, csr_rdata, csr_we, mult).
  - `mem_state_t` enum (RUN, MISS_WAIT).
- Sub-module `mem2wbk_fifo`: 2-entry FIFO of `mem2wbk_entry_t`, with `push`/`pop`/`full`/`empty`, same clock and reset. Alignment and extension logic stays in `mem_stage`.

## Test plan
- **Non-memory op.** ALU op `res`=0x1234, dest 5, `WB`=1 → next cycle `MEM_RES_RM`=0x1234, `MEM_DEST_RM`=5, `EMPTY`=0.
- **Signed byte load.** lb at 0x1003, cache word 0x80FF_0000, `SIGN`=1 → `res`=0xFFFF_FF80. Same access with lbu → 0x0000_0080.
- **Halfword store.** sh 0xABCD at 0x2002 → `BYT_SEL`=1100, `DATA`=0xABCD_ABCD, `WE`=1, pushed `res`=0.
- **Cache miss.** lw, `STALL` held 3 cycles → `VALID` held 4 cycles with the same address, a single pop, result visible 1 cycle after `STALL` drops.
- **FIFO full.** WBK never pops → after 2 pushes `EXE2MEM_POP_SM`=0. One WBK pop → next instruction pushes.
- **Misaligned and reset.** lw at 0x3001 → `MISALIGN_SM` 1-cycle pulse, no `VALID`, entry `WB`=0. Assert reset during MISS_WAIT → `VALID`=0 immediately, `EMPTY`=1.
